// File: rtl/tx_ramp_shaper.sv
// Transmit envelope shaper: linear gain ramp on key-down/key-up of the complex TX
// samples, plus a DAC gate that stays open until the shaped pipeline has drained.
module tx_ramp_shaper #(
    parameter int RAMP_LEN = 64,
    parameter int IN_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_en,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_real,
    input  logic signed [IN_W-1:0] in_imag,
    output logic                   out_valid,
    output logic signed [IN_W-1:0] out_real,
    output logic signed [IN_W-1:0] out_imag,
    output logic                   dac_gate,
    output logic [1:0]             state
);

    localparam int K  = $clog2(RAMP_LEN);
    localparam int GW = K + 1;
    localparam int PW = IN_W + K + 1;
    localparam logic [GW-1:0] G_MAX  = GW'(RAMP_LEN);
    localparam logic [GW-1:0] G_ZERO = GW'(0);
    localparam logic [GW-1:0] G_ONE  = GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    logic                   tx_meta_r;
    logic                   tx_sync_r;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [GW-1:0]          gain_r;
    logic [GW-1:0]          gain_nxt_s;
    logic                   idle_seen_r;
    logic                   dac_gate_r;
    logic                   gate_nxt_s;
    logic                   valid1_r;
    logic signed [PW-1:0]   in_real_ext_s;
    logic signed [PW-1:0]   in_imag_ext_s;
    logic signed [PW-1:0]   gain_ext_s;
    logic signed [PW-1:0]   prod_real_r;
    logic signed [PW-1:0]   prod_imag_r;
    logic                   out_valid_r;
    logic signed [IN_W-1:0] out_real_r;
    logic signed [IN_W-1:0] out_imag_r;

    // tx_en comes from an unrelated domain; two flops before any decision uses it
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_meta_r <= 1'b0;
            tx_sync_r <= 1'b0;
        end else begin
            tx_meta_r <= tx_en;
            tx_sync_r <= tx_meta_r;
        end
    end

    // Next state and gain; a direction change consumes the current sample at the old gain
    always_comb begin
        state_nxt_s = state_r;
        gain_nxt_s  = gain_r;
        case (state_r)
            ST_IDLE: begin
                gain_nxt_s = G_ZERO;
                if (tx_sync_r) begin
                    state_nxt_s = ST_RAMP_UP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RAMP_UP: begin
                if (!tx_sync_r) begin
                    state_nxt_s = ST_RAMP_DOWN;
                end else if (gain_r == G_MAX) begin
                    state_nxt_s = ST_ON;
                end else if (in_valid) begin
                    gain_nxt_s = gain_r + G_ONE;
                    if (gain_r == (G_MAX - G_ONE)) begin
                        state_nxt_s = ST_ON;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                    end
                end else begin
                    state_nxt_s = ST_RAMP_UP;
                end
            end
            ST_ON: begin
                gain_nxt_s = G_MAX;
                if (!tx_sync_r) begin
                    state_nxt_s = ST_RAMP_DOWN;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_RAMP_DOWN: begin
                if (tx_sync_r) begin
                    state_nxt_s = ST_RAMP_UP;
                end else if (gain_r == G_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else if (in_valid) begin
                    gain_nxt_s = gain_r - G_ONE;
                    if (gain_r == G_ONE) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RAMP_DOWN;
                    end
                end else begin
                    state_nxt_s = ST_RAMP_DOWN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gain_nxt_s  = G_ZERO;
            end
        endcase
    end

    // Gate opens as IDLE is left and closes only after two idle cycles have flushed the pipe
    always_comb begin
        gate_nxt_s = dac_gate_r;
        if (state_nxt_s != ST_IDLE) begin
            gate_nxt_s = 1'b1;
        end else if ((state_r == ST_IDLE) && idle_seen_r) begin
            gate_nxt_s = 1'b0;
        end else begin
            gate_nxt_s = dac_gate_r;
        end
    end

    // State, gain and gate registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            gain_r      <= G_ZERO;
            idle_seen_r <= 1'b0;
            dac_gate_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            gain_r      <= gain_nxt_s;
            idle_seen_r <= (state_r == ST_IDLE);
            dac_gate_r  <= gate_nxt_s;
        end
    end

    assign in_real_ext_s = {{GW{in_real[IN_W-1]}}, in_real};
    assign in_imag_ext_s = {{GW{in_imag[IN_W-1]}}, in_imag};
    assign gain_ext_s    = {{IN_W{1'b0}}, gain_r};

    // Two-stage datapath: full-width product, then floor shift back to IN_W
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_r    <= 1'b0;
            prod_real_r <= '0;
            prod_imag_r <= '0;
            out_valid_r <= 1'b0;
            out_real_r  <= '0;
            out_imag_r  <= '0;
        end else begin
            valid1_r    <= in_valid;
            out_valid_r <= valid1_r;
            if (in_valid) begin
                prod_real_r <= in_real_ext_s * gain_ext_s;
                prod_imag_r <= in_imag_ext_s * gain_ext_s;
            end
            if (valid1_r) begin
                out_real_r <= IN_W'(prod_real_r >>> K);
                out_imag_r <= IN_W'(prod_imag_r >>> K);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_real  = out_real_r;
    assign out_imag  = out_imag_r;
    assign dac_gate  = dac_gate_r;
    assign state     = state_r;

endmodule

// File: doc/tx_ramp_shaper.md
# tx_ramp_shaper

Transmit envelope shaper between the I2S receive path (baseband `tx_real`/`tx_imag`) and the `Transmitter`. It applies a linear amplitude ramp to the complex TX samples on key-down and key-up, so that CW keying and PTT edges produce no spectral clicks. It also generates a gate that enables the DAC path only while the envelope is non-zero or still draining through the pipeline.

## Interface

Parameters:
- `RAMP_LEN`, 64 — ramp length in input samples; power of two, range 2..256. `K = log2(RAMP_LEN)`.
- `IN_W`, 16 — sample width (signed, two's complement).

Ports:
- `clk`  in  1 — block clock; all logic on its rising edge.
- `reset`  in  1 — synchronous, active-high.
- `tx_en`  in  1 — key/PTT request (CW pin OR `s_rate[7]`); asynchronous to `clk`.
- `in_valid`  in  1 — one-cycle strobe, new input sample present.
- `in_real`, `in_imag`  in  IN_W — signed input sample.
- `out_valid`  out  1 — one-cycle strobe, output sample present.
- `out_real`, `out_imag`  out  IN_W — shaped signed sample; held between strobes.
- `dac_gate`  out  1 — DAC path enable.
- `state`  out  2 — IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3.

## Operation

- `tx_en` passes through a 2-flop synchronizer; all decisions use the synchronized `tx_en_s`.
- Gain counter `g` is K+1 bits wide, range 0..RAMP_LEN.
- Each accepted sample is multiplied by the current `g`; `g` updates on that same edge.
- Output is `(in * g) >>> K`, arithmetic shift (floor). No rounding and no saturation is needed, since `g = RAMP_LEN` returns `in` exactly. The product is IN_W+K+1 bits.
- State machine (state and `g` change only as listed):
  - IDLE: `g=0`. If `tx_en_s=1`, go to RAMP_UP on the next edge.
  - RAMP_UP: on each `in_valid`, `g+=1`. When `g` reaches RAMP_LEN, go to ON. If `tx_en_s=0`, go to RAMP_DOWN with no change to `g`.
  - ON: `g=RAMP_LEN`. If `tx_en_s=0`, go to RAMP_DOWN.
  - RAMP_DOWN: on each `in_valid`, `g-=1`. When `g` reaches 0, go to IDLE. If `tx_en_s=1`, go to RAMP_UP with no change to `g`.
- Direction reversal mid-ramp continues from the current `g`; the gain never jumps.
- A state change triggered by `tx_en_s` on a cycle with `in_valid` applies that sample with the old `g`. The new direction's step begins with the next sample.
- IDLE still passes samples: `out_valid` strobes, with zero data.
- `dac_gate`:
  - Rises on the edge where `state` leaves IDLE.
  - Falls 2 cycles after `state` enters IDLE, once the pipeline has drained.
  - If `state` leaves IDLE again during the drain, `dac_gate` stays high.

## Timing

- Latency: `out_valid` is asserted exactly 2 cycles after `in_valid`. Stage 1 registers the product; stage 2 registers the shift result.
- The pipeline is fully pipelined: `in_valid` may be asserted on every cycle.
- `tx_en` response: `tx_en` is sampled high at edge N, `tx_en_s` is high after edge N+1, and `state` changes at edge N+2.
- Reset, in any state including mid-ramp:
  - On the next edge: state=IDLE, `g=0`, synchronizer cleared.
  - All pipeline valids are cleared; in-flight samples are discarded (no `out_valid`).
  - `out_real`, `out_imag`, `dac_gate` and `out_valid` are 0.
  - `reset` has priority over every other input.
- Boundaries:
  - `g` never exceeds RAMP_LEN and never goes below 0.
  - A transition into ON or IDLE happens on the same edge that `g` reaches its limit.

## Test plan

- **Reset:** assert `reset` for 3 cycles with `tx_en=1` and `in_valid` toggling. Required: state=0, `out_real/out_imag/out_valid/dac_gate=0`. After release, state=1 appears at the 3rd edge.
- **Ramp up** (RAMP_LEN=64, `in_real=16384` constant, `in_imag=-16384`, `in_valid` every 4 cycles, `tx_en` rises):
  - Sample k of RAMP_UP gives `out_real=256k`, `out_imag=-256k`.
  - State=2 after the 64th sample.
  - All later outputs are 16384 / -16384.
  - `dac_gate=1` from the RAMP_UP entry onward.
- **Ramp down** (from ON, drop `tx_en`):
  - Outputs are 16384, 16128, …, 256, then 0.
  - State=0 after 64 samples.
  - `dac_gate` falls exactly 2 cycles after state=0.
- **Reversal:** after 10 RAMP_UP samples (`g=10`), drop `tx_en`.
  - Next outputs are 2560, 2304, …
  - Raise `tx_en` again at `g=5`: the following outputs climb from 1280 with no discontinuity.
- **Arithmetic:**
  - `in_real=-1` at `g=1` gives -1 (floor); `in_real=1` at `g=1` gives 0.
  - `in_real=-32768` in ON gives -32768.
  - Back-to-back `in_valid` on every cycle gives `out_valid` on every cycle, 2 cycles delayed.
- **Reset mid-operation:** assert `reset` for 1 cycle in RAMP_UP with 2 samples in flight. Required: no `out_valid` for those samples; state=0 and `g=0` on the next edge.
